regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 119 +++++++++++
 tb/tb_regfile_sb.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with a per-entry scoreboard.
// NRD combinational read ports, one write port, one debug read port, and a
// busy bit per entry that marks a pending producer. PendCnt is a registered
// count of busy entries.
// Optional feature: define REGFILE_SB_BYPASS_EN to forward the write port
// onto matching read ports in the same cycle. Without it, reads return only
// stored contents.
module regfile_sb #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int NRD      = 3,
    parameter int ZERO_REG = 1
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic [NRD*AW-1:0]   Ra,
    output logic [NRD*DW-1:0]   Da,
    output logic [NRD-1:0]      Busy,
    input  logic                RegWr,
    input  logic [AW-1:0]       Rw,
    input  logic [DW-1:0]       Dw,
    input  logic                Issue,
    input  logic [AW-1:0]       IssueRw,
    input  logic [AW-1:0]       DbgA,
    output logic [DW-1:0]       DbgD,
    output logic [AW:0]         PendCnt
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0]    regs [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;
    logic [AW:0]      pend_cnt;
    logic             wr_ok;
    logic             iss_ok;

    // Number of set bits in a busy vector; fits in AW+1 bits.
    function automatic logic [AW:0] popcount(input logic [DEPTH-1:0] v);
        logic [AW:0] cnt;
        cnt = '0;
        for (int k = 0; k < DEPTH; k++) begin
            cnt = cnt + (AW+1)'(v[k]);
        end
        return cnt;
    endfunction

    // Entry 0 is hard-wired when ZERO_REG is set: no writes, no busy.
    assign wr_ok  = RegWr && !((ZERO_REG != 0) && (Rw == '0));
    assign iss_ok = Issue && !((ZERO_REG != 0) && (IssueRw == '0));

    // Next busy vector: a write clears its entry, an issue sets it; set wins.
    always_comb begin
        busy_nxt = busy;
        for (int e = 0; e < DEPTH; e++) begin
            if (wr_ok && (Rw == AW'(e))) begin
                busy_nxt[e] = 1'b0;
            end
            if (iss_ok && (IssueRw == AW'(e))) begin
                busy_nxt[e] = 1'b1;
            end
        end
    end

    // Storage array: cleared by reset, written on the rising edge.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int e = 0; e < DEPTH; e++) begin
                regs[e] <= '0;
            end
        end else if (wr_ok) begin
            regs[Rw] <= Dw;
        end
    end

    // Scoreboard bits and their registered population count.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            busy     <= '0;
            pend_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            pend_cnt <= popcount(busy_nxt);
        end
    end

    assign PendCnt = pend_cnt;

    // Read ports: stored data and busy flag, optionally bypassed from the write port.
    always_comb begin
        Da   = '0;
        Busy = '0;
        for (int i = 0; i < NRD; i++) begin
            logic [AW-1:0] addr;
            addr = Ra[i*AW +: AW];
            if (!((ZERO_REG != 0) && (addr == '0))) begin
                Da[i*DW +: DW] = regs[addr];
            end
            Busy[i] = busy[addr];
`ifdef REGFILE_SB_BYPASS_EN
            if (wr_ok && (Rw == addr)) begin
                Da[i*DW +: DW] = Dw;
                if (!(iss_ok && (IssueRw == addr))) begin
                    Busy[i] = 1'b0;
                end
            end
`endif
        end
    end

    // Debug port always shows stored contents, never the bypass path.
    always_comb begin
        DbgD = '0;
        if (!((ZERO_REG != 0) && (DbgA == '0))) begin
            DbgD = regs[DbgA];
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed bench for regfile_sb with hand-computed expectations.
// Follows REGFILE_SB_BYPASS_EN the same way the design does.
module tb_regfile_sb;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NRD = 3;

    logic                CLK;
    logic                RESET_N;
    logic [NRD*AW-1:0]   Ra;
    logic [NRD*DW-1:0]   Da;
    logic [NRD-1:0]      Busy;
    logic                RegWr;
    logic [AW-1:0]       Rw;
    logic [DW-1:0]       Dw;
    logic                Issue;
    logic [AW-1:0]       IssueRw;
    logic [AW-1:0]       DbgA;
    logic [DW-1:0]       DbgD;
    logic [AW:0]         PendCnt;

    int n_chk;
    int n_pass;

    regfile_sb #(.DW(DW), .AW(AW), .NRD(NRD), .ZERO_REG(1)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .Ra      (Ra),
        .Da      (Da),
        .Busy    (Busy),
        .RegWr   (RegWr),
        .Rw      (Rw),
        .Dw      (Dw),
        .Issue   (Issue),
        .IssueRw (IssueRw),
        .DbgA    (DbgA),
        .DbgD    (DbgD),
        .PendCnt (PendCnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [NRD*DW-1:0] obs, input logic [NRD*DW-1:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        Ra = {a2, a1, a0};
    endtask

    initial begin
        logic [DW-1:0] exp_d;
        logic [NRD-1:0] exp_b;
        n_chk = 0;
        n_pass = 0;
        RESET_N = 1'b0;
        RegWr = 1'b0; Rw = '0; Dw = '0;
        Issue = 1'b0; IssueRw = '0;
        DbgA = '0;
        set_ra(0, 0, 0);
        tick();
        tick();
        RESET_N = 1'b1;
        #1;

        // Post-reset: every entry on every port reads zero and idle.
        chk("rst_pendcnt", PendCnt, 0);
        for (int a = 0; a < 32; a++) begin
            set_ra(AW'(a), AW'(a), AW'(a));
            DbgA = AW'(a);
            #1;
            chk($sformatf("rst_da_%0d", a), Da, 0);
            chk($sformatf("rst_busy_%0d", a), Busy, 0);
            chk($sformatf("rst_dbg_%0d", a), DbgD, 0);
        end

        // Write 5 while reading it on all ports.
        set_ra(5, 5, 5);
        DbgA = 5;
        RegWr = 1'b1; Rw = 5; Dw = 32'hDEADBEEF;
        #1;
`ifdef REGFILE_SB_BYPASS_EN
        exp_d = 32'hDEADBEEF;
`else
        exp_d = 32'h0;
`endif
        chk("wr5_same_cycle_da0", Da[DW-1:0], exp_d);
        chk("wr5_same_cycle_dbg", DbgD, 0);
        tick();
        RegWr = 1'b0;
        #1;
        chk("wr5_next_cycle_all", Da, {3{32'hDEADBEEF}});
        chk("wr5_next_cycle_dbg", DbgD, 32'hDEADBEEF);

        // Entry 0 discards writes and issues.
        set_ra(0, 0, 0);
        DbgA = 0;
        RegWr = 1'b1; Rw = 0; Dw = 32'h1234;
        #1;
        chk("zero_wr_same_cycle", Da, 0);
        tick();
        RegWr = 1'b0;
        #1;
        chk("zero_da", Da, 0);
        chk("zero_dbg", DbgD, 0);
        Issue = 1'b1; IssueRw = 0;
        tick();
        Issue = 1'b0;
        #1;
        chk("zero_issue_pend", PendCnt, 0);
        chk("zero_issue_busy", Busy, 0);

        // Issue 3, 7, 7 then retire 3.
        Issue = 1'b1; IssueRw = 3;
        tick();
        chk("iss3_pend", PendCnt, 1);
        IssueRw = 7;
        tick();
        chk("iss7_pend", PendCnt, 2);
        tick();
        chk("iss7_again_pend", PendCnt, 2);
        Issue = 1'b0;
        set_ra(3, 7, 1);
        #1;
        chk("busy_3_7_1", Busy, 3'b011);
        RegWr = 1'b1; Rw = 3; Dw = 32'h55;
        #1;
`ifdef REGFILE_SB_BYPASS_EN
        exp_b = 3'b010;
`else
        exp_b = 3'b011;
`endif
        chk("busy_during_wr3", Busy, exp_b);
        tick();
        RegWr = 1'b0;
        #1;
        chk("wr3_pend", PendCnt, 1);
        chk("wr3_busy", Busy, 3'b010);
        chk("wr3_da0", Da[DW-1:0], 32'h55);

        // Issue and write to 9 in the same cycle: busy stays set, data lands.
        set_ra(9, 9, 9);
        DbgA = 9;
        Issue = 1'b1; IssueRw = 9;
        RegWr = 1'b1; Rw = 9; Dw = 32'hA5A5;
        tick();
        Issue = 1'b0; RegWr = 1'b0;
        #1;
        chk("iss_wr9_busy", Busy, 3'b111);
        chk("iss_wr9_data", Da, {3{32'hA5A5}});
        chk("iss_wr9_dbg", DbgD, 32'hA5A5);
        chk("iss_wr9_pend", PendCnt, 2);

        // A write held only around the falling edge must not land.
        RegWr = 1'b1; Rw = 12; Dw = 32'h77;
        DbgA = 12;
        #5;
        RegWr = 1'b0;
        #1;
        chk("negedge_no_wr", DbgD, 0);
        tick();
        chk("negedge_no_wr_later", DbgD, 0);

        // Top entry.
        RegWr = 1'b1; Rw = 31; Dw = 32'hFFFFFFFF;
        tick();
        RegWr = 1'b0;
        set_ra(31, 31, 31);
        #1;
        chk("top_entry", Da, {3{32'hFFFFFFFF}});

        // Asynchronous reset in mid-cycle with populated state.
        set_ra(5, 9, 31);
        DbgA = 31;
        #2;
        RESET_N = 1'b0;
        #1;
        chk("async_rst_da", Da, 0);
        chk("async_rst_busy", Busy, 0);
        chk("async_rst_pend", PendCnt, 0);
        chk("async_rst_dbg", DbgD, 0);

        // Write and issue while reset is held are lost.
        RegWr = 1'b1; Rw = 20; Dw = 32'hBEEF;
        Issue = 1'b1; IssueRw = 20;
        tick();
        tick();
        RegWr = 1'b0; Issue = 1'b0;
        #2;
        RESET_N = 1'b1;
        DbgA = 20;
        #1;
        chk("rst_wr_lost", DbgD, 0);
        chk("rst_iss_lost", PendCnt, 0);

        // Normal operation resumes after release.
        RegWr = 1'b1; Rw = 20; Dw = 32'hBEEF;
        tick();
        RegWr = 1'b0;
        #1;
        chk("resume_wr", DbgD, 32'hBEEF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
